// File: rtl/mips_bus_pkg.sv
// Shared encodings for the sram-like bus arbiter: owner tags, access sizes, lock states.
package mips_bus_pkg;

  localparam logic       OWNER_INST = 1'b0;
  localparam logic       OWNER_DATA = 1'b1;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/owner_fifo.sv
// One-bit-wide in-order queue recording which port issued each accepted transaction.
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     push_owner,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_owner;
  end

endmodule

// File: rtl/sramlike_arbiter.sv
// Merges inst and data sram-like masters onto one port; an owner queue steers responses back in order.
module sramlike_arbiter
  import mips_bus_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  lock_state_e state_q, state_d;
  logic        lock_owner_q, lock_owner_d;
  logic        grant_owner;
  logic        owner;
  logic        req_int;
  logic        accept;
  logic        pop_ok;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;

  always_comb begin
    grant_owner = OWNER_INST;
    if (inst_req && data_req) grant_owner = DATA_PRIO ? OWNER_DATA : OWNER_INST;
    else if (data_req)        grant_owner = OWNER_DATA;
  end

  // A held lock overrides both arbitration and the full check so m_req never drops mid-handshake.
  assign owner   = (state_q == LOCK_HELD) ? lock_owner_q : grant_owner;
  assign req_int = (state_q == LOCK_HELD) || (!fifo_full && (inst_req || data_req));
  assign accept  = req_int && m_addr_ok;
  assign pop_ok  = m_data_ok && !fifo_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= LOCK_IDLE;
      lock_owner_q <= OWNER_INST;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    if (req_int && !m_addr_ok) begin
      state_d      = LOCK_HELD;
      lock_owner_d = owner;
    end else if (accept) begin
      state_d      = LOCK_IDLE;
    end
  end

  // rstn gates only the ports so every output reads 0 while reset is asserted.
  always_comb begin
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = '0;
    m_addr       = '0;
    m_wdata      = '0;
    if (rstn && req_int) begin
      m_req = 1'b1;
      if (owner == OWNER_DATA) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_addr  = inst_addr;
      end
    end
    inst_addr_ok = rstn && accept && (owner == OWNER_INST);
    data_addr_ok = rstn && accept && (owner == OWNER_DATA);
    inst_data_ok = rstn && pop_ok && (fifo_head == OWNER_INST);
    data_data_ok = rstn && pop_ok && (fifo_head == OWNER_DATA);
    inst_rdata   = rstn ? m_rdata : '0;
    data_rdata   = rstn ? m_rdata : '0;
  end

  owner_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (accept),
    .push_owner (owner),
    .pop        (pop_ok),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  spurious_data_ok: assert property (@(posedge clk) disable iff (!rstn) !(m_data_ok && fifo_count == '0))
    else $warning("m_data_ok with no outstanding transaction ignored");

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed and random stimulus for sramlike_arbiter, checked against a queue-based transaction model.
module tb_sramlike_arbiter;
  import mips_bus_pkg::*;

  localparam int DEPTH     = 2;
  localparam bit DATA_PRIO = 1'b1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [31:0] inst_addr, data_addr, data_wdata, inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  bit q[$];
  bit held;
  bit held_owner;

  always #5 clk = ~clk;

  sramlike_arbiter #(.DEPTH(DEPTH), .DATA_PRIO(DATA_PRIO)) dut (
    .clk(clk), .rstn(rstn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check combinational outputs against the model, then advance the model.
  task automatic step(input bit ir, input bit dr, input bit aok, input bit dok,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] rd);
    bit e_req, e_own, e_acc, e_pop, e_head;
    inst_req = ir; data_req = dr; m_addr_ok = aok; m_data_ok = dok;
    inst_addr = ia; data_addr = da; m_rdata = rd;
    inst_wr = 1'b0; inst_size = SIZE_WORD;
    data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 3));
    data_wdata = $urandom;
    #1;
    if (held) begin
      e_req = 1'b1; e_own = held_owner;
    end else if (q.size() < DEPTH && (ir || dr)) begin
      e_req = 1'b1; e_own = (ir && dr) ? DATA_PRIO : dr;
    end else begin
      e_req = 1'b0; e_own = 1'b0;
    end
    e_acc  = e_req && aok;
    e_pop  = dok && (q.size() > 0);
    e_head = (q.size() > 0) ? q[0] : 1'b0;
    chk("m_req", m_req, e_req);
    if (e_req) begin
      chk("m_addr", m_addr, e_own ? da : ia);
      chk("m_wdata", m_wdata, e_own ? data_wdata : 32'h0);
      chk("m_wr", m_wr, e_own ? data_wr : 1'b0);
      chk("m_size", m_size, e_own ? data_size : SIZE_WORD);
    end
    chk("inst_addr_ok", inst_addr_ok, e_acc && !e_own);
    chk("data_addr_ok", data_addr_ok, e_acc && e_own);
    chk("inst_data_ok", inst_data_ok, e_pop && !e_head);
    chk("data_data_ok", data_data_ok, e_pop && e_head);
    if (e_pop) chk(e_head ? "data_rdata" : "inst_rdata", e_head ? data_rdata : inst_rdata, rd);
    @(posedge clk);
    if (e_pop) void'(q.pop_front());
    if (e_acc) q.push_back(e_own);
    held       = e_req && !aok;
    held_owner = e_own;
    #1;
    chk("count", 32'(dut.u_fifo.count), 32'(q.size()));
    @(negedge clk);
  endtask

  initial begin
    bit ir, dr, aok, dok;
    held = 1'b0; held_owner = 1'b0;
    rstn = 1'b0;
    inst_req = 1'b1; data_req = 1'b0; inst_wr = 1'b0; data_wr = 1'b0;
    inst_size = SIZE_WORD; data_size = SIZE_WORD;
    inst_addr = 32'h1234; data_addr = 32'h5678; data_wdata = 32'h9abc;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hdead_beef;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    chk("rst_rdata", inst_rdata, 32'h0);
    chk("rst_count", 32'(dut.u_fifo.count), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // reset release: request passes straight through, then complete it
    step(1, 0, 1, 0, 32'h40, 32'h0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h1111);

    // tie: data port wins
    step(1, 1, 1, 0, 32'h44, 32'h88, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h2222);

    // lock: inst stalled three cycles, data arrives late and must wait
    repeat (3) step(1, 0, 0, 0, 32'h300, 32'h0, 32'h0);
    repeat (2) step(1, 1, 0, 0, 32'h300, 32'h400, 32'h0);
    step(1, 1, 1, 0, 32'h300, 32'h400, 32'h0);
    step(0, 1, 1, 1, 32'h0, 32'h400, 32'h3333);
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h4444);

    // in-order return to the right port
    step(1, 0, 1, 0, 32'h100, 32'h0, 32'h0);
    step(0, 1, 1, 0, 32'h0, 32'h200, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'hAAAA);
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'hBBBB);

    // full: pending request blocked, then push and pop at depth
    step(1, 0, 1, 0, 32'h500, 32'h0, 32'h0);
    step(0, 1, 1, 0, 32'h0, 32'h600, 32'h0);
    step(1, 1, 1, 0, 32'h504, 32'h604, 32'h0);
    step(1, 0, 0, 1, 32'h508, 32'h0, 32'h5555);
    step(1, 0, 1, 1, 32'h508, 32'h0, 32'h6666);
    step(0, 1, 1, 0, 32'h0, 32'h608, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h7777);
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h8888);

    // spurious return on an empty queue
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h9999);

    // reset with two outstanding
    step(1, 0, 1, 0, 32'h700, 32'h0, 32'h0);
    step(0, 1, 1, 0, 32'h0, 32'h800, 32'h0);
    inst_req = 1'b1;
    rstn = 1'b0;
    #1;
    chk("midrst_count", 32'(dut.u_fifo.count), 32'h0);
    chk("midrst_m_req", m_req, 1'b0);
    q.delete();
    held = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 0, 1, 32'h0, 32'h0, 32'h1234);

    // random traffic; addr_ok only offered when the downstream may legally accept
    for (int i = 0; i < 400; i++) begin
      ir  = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      dok = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      aok = 1'($urandom_range(0, 1)) && ((q.size() < DEPTH) || dok);
      step(ir, dr, aok, dok, $urandom, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
